huffman_act_enc: RTL

//  Huffman encoder for 4-bit activations, the transmit side of the serial activation link.

---
 rtl/huffman_pkg.sv | 50 +++++
 rtl/huffman_act_enc_if.sv | 23 ++
 rtl/huffman_code_lut.sv | 19 +
 rtl/huffman_act_enc.sv | 139 +++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared Huffman codebook for the 4-bit activation link (encoder and decoder).
// Holds the block geometry, the FSM state encoding and the symbol -> code table.
package huffman_pkg;

  localparam int unsigned NUM_WORDS    = 8;
  localparam int unsigned BW           = 4;
  localparam int unsigned BLK_W        = NUM_WORDS * BW;
  localparam int unsigned MAX_CODE_LEN = 11;
  localparam int unsigned LEN_W        = 4;
  localparam int unsigned PTR_W        = 3;
  localparam int unsigned STAT_W       = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } huff_state_e;

  // Code is left-aligned in MAX_CODE_LEN bits; len counts valid MSBs.
  typedef struct packed {
    logic [MAX_CODE_LEN-1:0] bits;
    logic [LEN_W-1:0]        len;
  } huff_code_t;

  // Prefix-free codebook; MSB of bits is transmitted first.
  function automatic huff_code_t huff_code(input logic [BW-1:0] sym);
    huff_code_t c;
    c.bits = '0;
    c.len  = '0;
    case (sym)
      4'd0:    begin c.bits = 11'b1_0000000000;  c.len = 4'd1;  end
      4'd1:    begin c.bits = 11'b0001_0000000;  c.len = 4'd4;  end
      4'd2:    begin c.bits = 11'b0000_0000000;  c.len = 4'd4;  end
      4'd3:    begin c.bits = 11'b0111_0000000;  c.len = 4'd4;  end
      4'd4:    begin c.bits = 11'b0011_0000000;  c.len = 4'd4;  end
      4'd5:    begin c.bits = 11'b0101_0000000;  c.len = 4'd4;  end
      4'd6:    begin c.bits = 11'b0100_0000000;  c.len = 4'd4;  end
      4'd7:    begin c.bits = 11'b0010_0000000;  c.len = 4'd4;  end
      4'd8:    begin c.bits = 11'b01101_000000;  c.len = 4'd5;  end
      4'd9:    begin c.bits = 11'b011001_00000;  c.len = 4'd6;  end
      4'd10:   begin c.bits = 11'b0110000_0000;  c.len = 4'd7;  end
      4'd11:   begin c.bits = 11'b011000111_00;  c.len = 4'd9;  end
      4'd12:   begin c.bits = 11'b01100010_000;  c.len = 4'd8;  end
      4'd13:   begin c.bits = 11'b01100011011;   c.len = 4'd11; end
      4'd14:   begin c.bits = 11'b01100011010;   c.len = 4'd11; end
      default: begin c.bits = 11'b0110001100_0;  c.len = 4'd10; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/huffman_act_enc_if.sv
// Block-in / serial-bit-out handshake bundle of the activation encoder.
interface huffman_act_enc_if;
  import huffman_pkg::*;

  logic [BLK_W-1:0] in;
  logic             valid_in;
  logic             ready;
  logic             out;
  logic             valid;
  logic             out_ready;

  // Block producer / bit consumer side.
  modport master (
    output in, valid_in, out_ready,
    input  ready, out, valid
  );

  // Encoder side.
  modport slave (
    input  in, valid_in, out_ready,
    output ready, out, valid
  );
endinterface

// File: rtl/huffman_code_lut.sv
// Combinational symbol -> left-aligned code and length lookup.
module huffman_code_lut
  import huffman_pkg::*;
(
  input  logic [BW-1:0]           sym_i,
  output logic [MAX_CODE_LEN-1:0] code_o,
  output logic [LEN_W-1:0]        len_o
);

  huff_code_t entry_c;

  // Table lookup from the shared codebook.
  always_comb begin
    entry_c = huff_code(sym_i);
    code_o  = entry_c.bits;
    len_o   = entry_c.len;
  end

endmodule

// File: rtl/huffman_act_enc.sv
// Huffman encoder for 4-bit activation blocks: serialises word 7 first, word 0 last.
// Optional HUFF_ENC_STATS_EN adds saturating transferred-bit and completed-block counters.
module huffman_act_enc
  import huffman_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  huffman_act_enc_if.slave    bus
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [STAT_W-1:0]   bit_count,
  output logic [STAT_W-1:0]   blk_count
`endif
);

  huff_state_e             state_q, state_d;
  logic [BLK_W-1:0]        hold_q, hold_d;
  logic [MAX_CODE_LEN-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]        bit_left_q, bit_left_d;
  logic [PTR_W-1:0]        word_ptr_q, word_ptr_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;

  logic [PTR_W-1:0]        nxt_ptr_c;
  logic [BW-1:0]           lut_sym_c;
  logic [MAX_CODE_LEN-1:0] lut_code_c;
  logic [LEN_W-1:0]        lut_len_c;
  logic                    xfer_c;
  logic                    last_bit_c;
  logic                    blk_done_c;

  // In IDLE the LUT sees the incoming top word; in SHIFT it pre-fetches the next held word.
  assign nxt_ptr_c  = word_ptr_q - PTR_W'(1);
  assign lut_sym_c  = (state_q == S_IDLE) ? bus.in[BLK_W-1 -: BW]
                                          : hold_q[{nxt_ptr_c, 2'b00} +: BW];
  assign xfer_c     = valid_q & bus.out_ready;
  assign last_bit_c = (bit_left_q == LEN_W'(1));
  assign blk_done_c = xfer_c & last_bit_c & (word_ptr_q == '0);

  huffman_code_lut u_lut (
    .sym_i  (lut_sym_c),
    .code_o (lut_code_c),
    .len_o  (lut_len_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      shift_q    <= '0;
      bit_left_q <= '0;
      word_ptr_q <= PTR_W'(NUM_WORDS - 1);
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      bit_left_q <= bit_left_d;
      word_ptr_q <= word_ptr_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state: accept a block, then shift codes back-to-back with no inter-word bubble.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    bit_left_d = bit_left_q;
    word_ptr_d = word_ptr_q;
    valid_d    = valid_q;
    ready_d    = ready_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_in && ready_q) begin
          hold_d     = bus.in;
          shift_d    = lut_code_c;
          bit_left_d = lut_len_c;
          word_ptr_d = PTR_W'(NUM_WORDS - 1);
          valid_d    = 1'b1;
          ready_d    = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (xfer_c) begin
          if (blk_done_c) begin
            shift_d    = '0;
            bit_left_d = '0;
            word_ptr_d = PTR_W'(NUM_WORDS - 1);
            valid_d    = 1'b0;
            ready_d    = 1'b1;
            state_d    = S_IDLE;
          end else if (last_bit_c) begin
            shift_d    = lut_code_c;
            bit_left_d = lut_len_c;
            word_ptr_d = nxt_ptr_c;
          end else begin
            shift_d    = {shift_q[MAX_CODE_LEN-2:0], 1'b0};
            bit_left_d = bit_left_q - LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.out   = shift_q[MAX_CODE_LEN-1];
  assign bus.valid = valid_q;
  assign bus.ready = ready_q;

`ifdef HUFF_ENC_STATS_EN
  logic [STAT_W-1:0] bit_count_q;
  logic [STAT_W-1:0] blk_count_q;

  // Saturating counters for compression-ratio measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count_q <= '0;
      blk_count_q <= '0;
    end else begin
      if (xfer_c && (bit_count_q != '1)) bit_count_q <= bit_count_q + STAT_W'(1);
      if (blk_done_c && (blk_count_q != '1)) blk_count_q <= blk_count_q + STAT_W'(1);
    end
  end

  assign bit_count = bit_count_q;
  assign blk_count = blk_count_q;
`endif

endmodule
